pwm_multi_channel: RTL
======================

Name: pwm_multi_channel

Overview:
- Multi-channel PWM generator built around a shared period counter. It supports edge-aligned and center-aligned modes, per-channel duty and output polarity.
- Configuration is double-buffered: new settings go into shadow registers and reach the active registers only at a period boundary, so no output ever shows a truncated or glitched pulse.
- Sits between the tone/envelope control logic and the output pads. It replaces single-channel PWM instances where several channels must share one period.

Parameters:
- BW, 8, width of counter, period and each duty value
- NCH, 4, number of PWM output channels

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  counter enable; low = idle
- load_i  in  1  one-cycle strobe; captures all configuration inputs into shadow registers
- period_i  in  BW  period value P
- center_i  in  1  mode: 0 = edge-aligned, 1 = center-aligned
- duty_i  in  NCH*BW  duty per channel; channel k occupies bits [k*BW +: BW]
- pol_i  in  NCH  per-channel polarity; 1 = inverted output
- pwm_o  out  NCH  registered PWM outputs
- sync_o  out  1  registered one-cycle pulse marking the start of each period
- pending_o  out  1  shadow holds values not yet applied

Behaviour:
- Reset (rst_i=1 at clk edge), all state cleared:
  - counter cnt=0, direction dir=up
  - shadow and active period/duty/pol/center registers = 0
  - pending_o=0, pwm_o=0, sync_o=0
- Shadow load:
  - load_i=1 captures period_i, center_i, duty_i and pol_i into the shadow registers.
  - pending_o=1 from the next cycle.
  - load_i while pending_o=1 overwrites the shadow; only the last load applies.
- Boundary:
  - Edge mode: the cycle where cnt >= P_active.
  - Center mode: the cycle where dir=down and cnt==1, or where P_active==0.
  - In a boundary cycle with pending_o=1: active <= shadow, pending_o <= 0.
  - If load_i is also 1 in that cycle: the previous shadow contents transfer, the new values enter the shadow, and pending_o stays 1.
- Edge mode counter: 0,1,..,P, then 0. Period = P+1 cycles.
- Center mode counter:
  - Up 0..P, then down P-1..1, then 0. Period = 2P cycles.
  - dir flips to down at cnt==P and to up at cnt==0.
  - P=0: cnt held at 0, boundary every cycle.
- Compare: raw_k = (cnt < duty_k), unsigned BW-bit compare.
  - duty_k=0: constant inactive level.
  - duty_k>P (edge mode) or duty_k>P (center mode): constant active level.
  - Edge mode: high for duty_k cycles of P+1.
  - Center mode: high for 2*duty_k-1 cycles of 2P, for 1<=duty_k<=P; the pulse is centered on cnt=0.
- Output register: pwm_o[k] <= raw_k XOR pol_active[k].
  - Latency is 1 cycle from cnt to pwm_o.
  - sync_o <= (cnt==0) & en_i, so it is aligned with pwm_o.
- Mode change (center_i) takes effect only via a shadow transfer.
  - On a transfer that changes mode, the counter restarts at cnt=0, dir=up.
- Disable (en_i=0):
  - cnt <= 0, dir <= up.
  - pwm_o <= pol_active (inactive level), sync_o <= 0.
  - Pending shadow transfers every cycle, so the new config is ready when enabled.
- Re-enable: counting starts at cnt=0. The first sync_o fires 1 cycle after en_i rises.
- Wrap safety: in edge mode, cnt > P_active (unreachable in normal operation) is treated as a boundary and wraps to 0.
- Reset mid-period: state is immediately cleared per the reset values above; no partial pulse completes.

Test Plan:
- BW=8, NCH=4, load P=9, duty={0,3,10,255}, pol=0, edge mode, en=1:
  - ch0 constant 0; ch1 high 3 of 10 cycles; ch2 and ch3 constant 1.
  - sync_o every 10 cycles.
- Center mode P=4, duty1=2: period 8 cycles, ch1 high 3 cycles centered on cnt=0; sync_o every 8 cycles.
- Mid-period load changing duty1 3→7 at cnt=4:
  - Current period keeps duty 3; next period (after sync_o) shows 7.
  - pending_o is 1 from load+1 until the boundary cycle +1.
- Two loads before the boundary (duty 5, then 6): only 6 applies. Load coinciding with the boundary cycle: the old shadow applies now, the new value the period after.
- en_i=0 with pol={1,0,1,0}: pwm_o=4'b0101 after 1 cycle, sync_o=0, cnt=0. Re-enable: sync_o fires on the next cycle.
- Assert rst_i mid-period (cnt=5) with pending_o=1: the next cycle has pwm_o=0, sync_o=0, pending_o=0. The active config is 0, so outputs stay low after release.

Source files
------------

// File: rtl/pwm_multi_channel_if.sv
// Configuration and output bundle of the multi-channel PWM generator.
// master drives the configuration; slave is the PWM core and drives the outputs.
interface pwm_multi_channel_if #(
   parameter int BW  = 8,
   parameter int NCH = 4
);
   logic                en_i;
   logic                load_i;
   logic [BW-1:0]       period_i;
   logic                center_i;
   logic [NCH*BW-1:0]   duty_i;
   logic [NCH-1:0]      pol_i;
   logic [NCH-1:0]      pwm_o;
   logic                sync_o;
   logic                pending_o;

   modport master (
      output en_i, load_i, period_i, center_i, duty_i, pol_i,
      input  pwm_o, sync_o, pending_o
   );

   modport slave (
      input  en_i, load_i, period_i, center_i, duty_i, pol_i,
      output pwm_o, sync_o, pending_o
   );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM on one shared period counter, edge/center aligned, double-buffered config.
// Latency: 1 cycle from counter to pwm_o/sync_o; no backpressure, the counter free-runs while en_i=1.
module pwm_multi_channel #(
   parameter int BW  = 8,
   parameter int NCH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   pwm_multi_channel_if.slave     bus
);

   logic [BW-1:0]       r_cnt;
   logic                r_dir_dn;

   logic [BW-1:0]       r_sh_period;
   logic                r_sh_center;
   logic [NCH*BW-1:0]   r_sh_duty;
   logic [NCH-1:0]      r_sh_pol;

   logic [BW-1:0]       r_act_period;
   logic                r_act_center;
   logic [NCH*BW-1:0]   r_act_duty;
   logic [NCH-1:0]      r_act_pol;

   logic                r_pending;
   logic [NCH-1:0]      r_pwm;
   logic                r_sync;

   logic                w_boundary;
   logic                w_transfer;
   logic [BW-1:0]       w_cnt_nxt;
   logic                w_dir_nxt;
   logic [NCH-1:0]      w_raw;

   // Edge mode treats any cnt beyond the period as a boundary so a stray count always wraps.
   always_comb begin
      w_boundary = 1'b0;
      if (!r_act_center) begin
         w_boundary = (r_cnt >= r_act_period);
      end else begin
         w_boundary = (r_dir_dn && (r_cnt == BW'(1))) || (r_act_period == '0);
      end
   end

   // While disabled the shadow is applied every cycle so the config is ready on enable.
   assign w_transfer = r_pending && (w_boundary || !bus.en_i);

   // Every transfer lands on a boundary or on a disabled cycle, both of which restart the
   // counter at 0/up, so a mode change never inherits a half-finished sweep.
   always_comb begin
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
      if (!bus.en_i || w_boundary) begin
         w_cnt_nxt = '0;
         w_dir_nxt = 1'b0;
      end else if (!r_act_center) begin
         w_cnt_nxt = r_cnt + BW'(1);
      end else if (!r_dir_dn) begin
         w_cnt_nxt = r_cnt + BW'(1);
         w_dir_nxt = (w_cnt_nxt >= r_act_period);
      end else if (r_cnt > BW'(1)) begin
         w_cnt_nxt = r_cnt - BW'(1);
         w_dir_nxt = 1'b1;
      end
   end

   always_comb begin
      w_raw = '0;
      for (int k = 0; k < NCH; k++) begin
         w_raw[k] = (r_cnt < r_act_duty[k*BW +: BW]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt        <= '0;
         r_dir_dn     <= 1'b0;
         r_sh_period  <= '0;
         r_sh_center  <= 1'b0;
         r_sh_duty    <= '0;
         r_sh_pol     <= '0;
         r_act_period <= '0;
         r_act_center <= 1'b0;
         r_act_duty   <= '0;
         r_act_pol    <= '0;
         r_pending    <= 1'b0;
         r_pwm        <= '0;
         r_sync       <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_nxt;
         r_dir_dn <= w_dir_nxt;

         if (bus.en_i) begin
            r_pwm  <= w_raw ^ r_act_pol;
            r_sync <= (r_cnt == '0);
         end else begin
            r_pwm  <= r_act_pol;
            r_sync <= 1'b0;
         end

         // The outgoing shadow transfers before a same-cycle load replaces it.
         if (w_transfer) begin
            r_act_period <= r_sh_period;
            r_act_center <= r_sh_center;
            r_act_duty   <= r_sh_duty;
            r_act_pol    <= r_sh_pol;
         end

         if (bus.load_i) begin
            r_sh_period <= bus.period_i;
            r_sh_center <= bus.center_i;
            r_sh_duty   <= bus.duty_i;
            r_sh_pol    <= bus.pol_i;
            r_pending   <= 1'b1;
         end else if (w_transfer) begin
            r_pending   <= 1'b0;
         end
      end
   end

   assign bus.pwm_o     = r_pwm;
   assign bus.sync_o    = r_sync;
   assign bus.pending_o = r_pending;

endmodule
